// File: rtl/counter_bank_if.sv
// Counter bank bus: per-channel controls, packed limits/load data,
// and the registered counts, terminal-count and wrap flags.
interface counter_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16
);
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH-1:0]       ld;
  logic [NUM_CH*WIDTH-1:0] ld_data;
  logic [NUM_CH-1:0]       inc;
  logic [NUM_CH*WIDTH-1:0] limit;
  logic [NUM_CH*WIDTH-1:0] cnt;
  logic [NUM_CH-1:0]       tc;
  logic [NUM_CH-1:0]       wrap;

  modport master (
    output clr, ld, ld_data, inc, limit,
    input  cnt, tc, wrap
  );

  modport slave (
    input  clr, ld, ld_data, inc, limit,
    output cnt, tc, wrap
  );
endinterface

// File: rtl/counter_bank.sv
// Bank of NUM_CH wrap-at-limit counters with clr/ld/inc per channel
// and an optional same-cycle ripple carry from channel i-1 into i.
module counter_bank #(
  parameter int              WIDTH     = 16,
  parameter int              NUM_CH    = 4,
  parameter bit              CASCADE   = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic           clk,
  input logic           rst_n,
  counter_bank_if.slave bus
);

  logic [WIDTH-1:0]  cnt_q [NUM_CH];
  logic [WIDTH-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] inc_eff;
  logic [NUM_CH-1:0] wev;
  logic [NUM_CH-1:0] wrap_q;
  logic              carry;
  logic              at_top;

  // Carry ripples through every channel within the same cycle.
  always_comb begin
    inc_eff = '0;
    wev     = '0;
    carry   = 1'b0;
    at_top  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      inc_eff[i] = bus.inc[i] | (CASCADE & carry);
      at_top     = (cnt_q[i] == bus.limit[i*WIDTH +: WIDTH]) ||
                   (cnt_q[i] == {WIDTH{1'b1}});
      wev[i]     = inc_eff[i] & ~bus.clr[i] & ~bus.ld[i] & at_top;
      if (bus.clr[i])
        cnt_d[i] = '0;
      else if (bus.ld[i])
        cnt_d[i] = bus.ld_data[i*WIDTH +: WIDTH];
      else if (inc_eff[i])
        cnt_d[i] = wev[i] ? '0 : cnt_q[i] + 1'b1;
      carry = wev[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= RESET_VAL;
      wrap_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= cnt_d[i];
      wrap_q <= wev;
    end
  end

  always_comb begin
    bus.cnt = '0;
    bus.tc  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.cnt[i*WIDTH +: WIDTH] = cnt_q[i];
      bus.tc[i] = (cnt_q[i] == bus.limit[i*WIDTH +: WIDTH]);
    end
  end

  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_counter_bank.sv
// Table-driven bench for counter_bank (CASCADE=1, 4 x 16-bit),
// with a scoreboard queue of expected post-edge results.
module tb_counter_bank;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter_bank_if #(.NUM_CH(N), .WIDTH(W)) bus ();

  counter_bank #(
    .WIDTH(W), .NUM_CH(N), .CASCADE(1'b1), .RESET_VAL(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [3:0]  clr;
    logic [3:0]  ld;
    logic [3:0]  inc;
    logic [15:0] ldd0;
    logic [15:0] lim0;
    logic [15:0] lim1;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [1:0]  ewrap;
    logic        etc0;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.clr     = v.clr;
    bus.ld      = v.ld;
    bus.inc     = v.inc;
    bus.ld_data = {48'h0, v.ldd0};
    bus.limit   = {16'hFFFF, 16'hFFFF, v.lim1, v.lim0};
  endtask

  task automatic step(vec_t v, int idx);
    vec_t e;
    @(negedge clk);
    drive(v);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("v%0d cnt0", idx), 32'(bus.cnt[15:0]), 32'(e.e0));
    check($sformatf("v%0d cnt1", idx), 32'(bus.cnt[31:16]), 32'(e.e1));
    check($sformatf("v%0d wrap", idx), 32'(bus.wrap[1:0]), 32'(e.ewrap));
    check($sformatf("v%0d tc0", idx), 32'(bus.tc[0]), 32'(e.etc0));
  endtask

  function automatic vec_t mk(logic [3:0] c, logic [3:0] l,
      logic [3:0] i, logic [15:0] d, logic [15:0] l0,
      logic [15:0] l1, logic [15:0] e0, logic [15:0] e1,
      logic [1:0] w, logic t);
    vec_t v;
    v.clr = c; v.ld = l; v.inc = i; v.ldd0 = d;
    v.lim0 = l0; v.lim1 = l1; v.e0 = e0; v.e1 = e1;
    v.ewrap = w; v.etc0 = t;
    return v;
  endfunction

  vec_t hv;

  initial begin
    //            clr   ld    inc   ldd      lim0  lim1     e0       e1 wrap tc0
    // basic wrap, limit0=3
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd3, 16'hFFFF, 16'd1, 16'd0, 2'b00, 1'b0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd3, 16'hFFFF, 16'd2, 16'd0, 2'b00, 1'b0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd3, 16'hFFFF, 16'd3, 16'd0, 2'b00, 1'b1));
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd3, 16'hFFFF, 16'd0, 16'd1, 2'b01, 1'b0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd3, 16'hFFFF, 16'd1, 16'd1, 2'b00, 1'b0));
    // priority clr > ld > inc
    vecs.push_back(mk(4'h1, 4'h1, 4'h1, 16'h1234, 16'd3, 16'hFFFF, 16'd0, 16'd1, 2'b00, 1'b0));
    vecs.push_back(mk(4'h0, 4'h1, 4'h1, 16'h1234, 16'd3, 16'hFFFF, 16'h1234, 16'd1, 2'b00, 1'b0));
    // load above limit, count to all-ones then wrap
    vecs.push_back(mk(4'h0, 4'h1, 4'h0, 16'hFFFE, 16'd5, 16'hFFFF, 16'hFFFE, 16'd1, 2'b00, 1'b0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd5, 16'hFFFF, 16'hFFFF, 16'd1, 2'b00, 1'b0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd5, 16'hFFFF, 16'd0, 16'd2, 2'b01, 1'b0));
    vecs.push_back(mk(4'h3, 4'h0, 4'h0, 16'h0, 16'd5, 16'hFFFF, 16'd0, 16'd0, 2'b00, 1'b0));
    // cascade, limits 2 and 1
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd2, 16'd1, 16'd1, 16'd0, 2'b00, 1'b0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd2, 16'd1, 16'd2, 16'd0, 2'b00, 1'b1));
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd2, 16'd1, 16'd0, 16'd1, 2'b01, 1'b0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd2, 16'd1, 16'd1, 16'd1, 2'b00, 1'b0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd2, 16'd1, 16'd2, 16'd1, 2'b00, 1'b1));
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd2, 16'd1, 16'd0, 16'd0, 2'b11, 1'b0));
    // limit0=0 plus inc1 with carry: single increment of ch1
    vecs.push_back(mk(4'h0, 4'h0, 4'h3, 16'h0, 16'd0, 16'd5, 16'd0, 16'd1, 2'b01, 1'b1));
    vecs.push_back(mk(4'h0, 4'h0, 4'h3, 16'h0, 16'd0, 16'd5, 16'd0, 16'd2, 2'b01, 1'b1));
    // reach limit0=1, then ld suppresses carry
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd1, 16'd5, 16'd1, 16'd2, 2'b00, 1'b1));
    vecs.push_back(mk(4'h0, 4'h1, 4'h1, 16'h7, 16'd1, 16'd5, 16'd7, 16'd2, 2'b00, 1'b0));
    // limit change takes effect in the same cycle
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd7, 16'd5, 16'd0, 16'd3, 2'b01, 1'b0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 16'h0, 16'd0, 16'd5, 16'd0, 16'd3, 2'b00, 1'b1));

    hv = mk(4'h0, 4'h0, 4'h0, 16'h0, 16'd0, 16'hFFFF, 16'd0, 16'd0, 2'b00, 1'b0);
    drive(hv);
    #12;
    check("rst cnt", bus.cnt[31:0], 32'h0);
    check("rst wrap", 32'(bus.wrap), 32'h0);
    check("rst tc0", 32'(bus.tc[0]), 32'h1);
    hv.lim0 = 16'd3;
    drive(hv);
    #1;
    check("rst tc0 lim3", 32'(bus.tc[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++)
      step(vecs[k], k);

    // reset mid-operation with a wrap about to happen
    step(mk(4'h3, 4'h0, 4'h0, 16'h0, 16'd2, 16'd5, 16'd0, 16'd0, 2'b00, 1'b0), 100);
    step(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd2, 16'd5, 16'd1, 16'd0, 2'b00, 1'b0), 101);
    step(mk(4'h0, 4'h0, 4'h1, 16'h0, 16'd2, 16'd5, 16'd2, 16'd0, 2'b00, 1'b1), 102);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst cnt0", 32'(bus.cnt[15:0]), 32'h0);
    check("async rst wrap", 32'(bus.wrap), 32'h0);
    @(posedge clk);
    #1;
    check("held rst cnt0", 32'(bus.cnt[15:0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.inc = '0;
    @(posedge clk);
    #1;
    check("post rst wrap", 32'(bus.wrap), 32'h0);
    check("post rst cnt0", 32'(bus.cnt[15:0]), 32'h0);

    check("sb empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the bit width of each channel counter.
REQ-002 The block SHALL have parameter NUM_CH, default 4, giving the number of independent counter channels (1..16).
REQ-003 The block SHALL have parameter CASCADE, default 0; when 1, the wrap of channel i-1 carries into channel i.
REQ-004 The block SHALL have parameter RESET_VAL, default 0, the WIDTH-bit value each counter takes on reset.
REQ-005 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port clr, input, NUM_CH bits: per-channel synchronous clear to 0.
REQ-008 Port ld, input, NUM_CH bits: per-channel synchronous load strobe.
REQ-009 Port ld_data, input, NUM_CH*WIDTH bits: load values; channel i uses bits [i*WIDTH +: WIDTH].
REQ-010 Port inc, input, NUM_CH bits: per-channel increment request.
REQ-011 Port limit, input, NUM_CH*WIDTH bits: per-channel terminal value; same packing as ld_data.
REQ-012 Port cnt, output, NUM_CH*WIDTH bits: registered counter values; same packing.
REQ-013 Port tc, output, NUM_CH bits: terminal-count flag, tc[i] = (cnt_i == limit_i), combinational from registered cnt and the current limit.
REQ-014 Port wrap, output, NUM_CH bits: registered one-cycle pulse, high in the cycle after channel i wrapped.

Function
REQ-015 Per channel, the priority SHALL be clr > ld > effective increment > hold.
REQ-016 clr[i]=1 SHALL set cnt_i to 0 on the next edge; ld and inc for that channel are ignored that cycle.
REQ-017 ld[i]=1 with clr[i]=0 SHALL set cnt_i to ld_data_i on the next edge; values above limit_i are accepted.
REQ-018 Effective increment SHALL be inc_eff[0] = inc[0].
REQ-019 For i>0, effective increment SHALL be inc_eff[i] = inc[i] OR (CASCADE AND wev[i-1]).
REQ-020 The wrap event SHALL be defined as wev[i] = inc_eff[i] AND !clr[i] AND !ld[i] AND (cnt_i == limit_i OR cnt_i == all-ones).
REQ-021 The carry chain SHALL be combinational and ripple through all channels within one cycle, with no added latency.
REQ-022 When inc_eff[i] is active and neither clr[i] nor ld[i] is asserted, the next cnt_i SHALL be 0 if wev[i], else cnt_i+1; increment latency is 1 cycle.
REQ-023 The next wrap[i] SHALL equal wev[i]; wrap SHALL be 0 in every cycle without a wrap event.
REQ-024 limit_i = 0 SHALL hold cnt_i at 0 and produce a wrap pulse for every effective increment.
REQ-025 A counter loaded above limit_i SHALL count up to all-ones, then wrap to 0 with a wrap pulse.
REQ-026 With CASCADE=1, inc[i] together with a carry into channel i SHALL produce a single increment, not +2.
REQ-027 A clr or ld on channel i-1 SHALL suppress that channel's carry to channel i in the same cycle.
REQ-028 A change to limit_i SHALL take effect in the same cycle for the tc and wrap decisions.
REQ-029 When CASCADE=0, the channels SHALL be fully independent.

Reset
REQ-030 While rst_n=0, every cnt_i SHALL equal RESET_VAL and wrap SHALL be 0, immediately and without waiting for a clock edge.
REQ-031 Reset asserted mid-count SHALL discard all in-flight increments; no wrap pulse SHALL follow reset release.
REQ-032 The first state update SHALL occur on the first rising clk edge after rst_n rises; tc is valid throughout reset.

Verification
REQ-033 Basic wrap (WIDTH=16, limit0=3, inc0 held for 5 cycles from reset): cnt0 = 1,2,3,0,1; wrap0 pulses once, in the cycle cnt0 becomes 0; tc0 is high while cnt0=3.
REQ-034 Priority: clr0=ld0=inc0=1 with ld_data0=0x1234 -> cnt0=0; then ld0=inc0=1 -> cnt0=0x1234.
REQ-035 Cascade (CASCADE=1, limits 2,1, inc0 held) -> (cnt0,cnt1) sequence (1,0),(2,0),(0,1),(1,1),(2,1),(0,0); wrap1 pulses on the last step.
REQ-036 Overload: ld0 with 0xFFFE and limit0=5, then inc0 for 2 cycles -> cnt0 = 0xFFFF, then 0x0000 with a wrap0 pulse.
REQ-037 Reset mid-operation: rst_n pulled low between clock edges while cnt0=2 -> cnt0=RESET_VAL and wrap=0 at once; no wrap pulse after release.
REQ-038 Suppressed carry (CASCADE=1): cnt0=limit0, inc0=1, ld0=1 -> cnt1 unchanged and wrap0=0.
